// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard stall controller: register/timing
// field widths, Tuse/Tnew encodings, MULT/DIV latency defaults, the MD
// timer state type and the single-operand RAW hazard check.
// This package sits alongside the core's existing `define macros.
package hazard_stall_ctrl_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned T_W      = 2;
  localparam int unsigned MD_CNT_W = 4;
  localparam int unsigned STAT_W   = 32;

  localparam logic [T_W-1:0]   TUSE_NONE = 2'd3;
  localparam logic [T_W-1:0]   TNEW_NOW  = 2'd0;
  localparam logic [REG_W-1:0] REG_ZERO  = 5'd0;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Result producer in a later stage: destination register and cycles until ready.
  typedef struct packed {
    logic [REG_W-1:0] waddr;
    logic [T_W-1:0]   tnew;
  } wb_src_t;

  // A D-stage operand must stall when its producer is further away than the consumer.
  function automatic logic raw_hazard(input logic [REG_W-1:0] a,
                                      input logic [T_W-1:0]   tuse,
                                      input wb_src_t          src);
    return (a != REG_ZERO) && (a == src.waddr) && (tuse != TUSE_NONE) &&
           (src.tnew != TNEW_NOW) && (tuse < src.tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// md_busy_timer: MULT/DIV busy window tracker.
// A start pulse loads the down counter with the operation latency (a start
// while busy restarts the window); md_busy is high while the count is nonzero.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        MULT/DIV start pulse from E
//   is_div       1 = DIV*, 0 = MULT*, qualifies start
//   md_busy      registered busy flag
module md_busy_timer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);
  localparam logic [MD_CNT_W-1:0] CNT_ONE   = MD_CNT_W'(1);

  logic [MD_CNT_W-1:0] cnt;
  md_state_t           state;

  // State, counter and busy flag share one register process; busy mirrors (cnt != 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state   <= MD_BUSY;
            cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
            md_busy <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (start) begin
            cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
            md_busy <= 1'b1;
          end else if (cnt == CNT_ONE || cnt == '0) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
          end else begin
            cnt     <= cnt - CNT_ONE;
            md_busy <= 1'b1;
          end
        end
        default: begin
          state   <= MD_IDLE;
          cnt     <= '0;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: D-stage stall/flush controller for the 5-stage core.
// Detects Tuse/Tnew data hazards forwarding cannot resolve and MULT/DIV
// busy conflicts; stalls PC and IF/ID and bubbles ID/EX in the same cycle.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   a1_d, a2_d, tuse_*_d       D-stage source registers and their Tuse
//   waddr_e/tnew_e, waddr_m/tnew_m  producers in E and M
//   md_use_d, md_start_e, md_is_div_e  MULT/DIV usage and start
//   en_pc, en_ifid, clr_idex   pipeline register controls
//   md_busy                    MULT/DIV busy flag
//   stall_cnt, md_stall_cnt    saturating stall statistics (0 when disabled)
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  a1_d,
  input  logic [REG_W-1:0]  a2_d,
  input  logic [T_W-1:0]    tuse_rs_d,
  input  logic [T_W-1:0]    tuse_rt_d,
  input  logic [REG_W-1:0]  waddr_e,
  input  logic [T_W-1:0]    tnew_e,
  input  logic [REG_W-1:0]  waddr_m,
  input  logic [T_W-1:0]    tnew_m,
  input  logic              md_use_d,
  input  logic              md_start_e,
  input  logic              md_is_div_e,
  output logic              en_pc,
  output logic              en_ifid,
  output logic              clr_idex,
  output logic              md_busy,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] md_stall_cnt
);

  wb_src_t src_e;
  wb_src_t src_m;
  logic    data_stall;
  logic    md_stall;
  logic    stall;

  assign src_e = '{waddr: waddr_e, tnew: tnew_e};
  assign src_m = '{waddr: waddr_m, tnew: tnew_m};

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (md_start_e),
    .is_div  (md_is_div_e),
    .md_busy (md_busy)
  );

  // Hazard detection is purely combinational so the stall takes effect this cycle.
  always_comb begin
    data_stall = raw_hazard(a1_d, tuse_rs_d, src_e) |
                 raw_hazard(a1_d, tuse_rs_d, src_m) |
                 raw_hazard(a2_d, tuse_rt_d, src_e) |
                 raw_hazard(a2_d, tuse_rt_d, src_m);
    md_stall   = md_use_d & (md_busy | md_start_e);
    stall      = (data_stall | md_stall) & ~reset;
  end

  // Pipeline keeps flowing while in reset; the registers clear themselves.
  assign en_pc    = ~stall;
  assign en_ifid  = ~stall;
  assign clr_idex = stall;

`ifdef HAZARD_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  logic md_stall_q;

  assign md_stall_q = md_stall & ~reset;

  // Saturating counters: a simultaneous data+MD stall counts once in each.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall && stall_cnt != STAT_MAX) begin
        stall_cnt <= stall_cnt + STAT_ONE;
      end
      if (md_stall_q && md_stall_cnt != STAT_MAX) begin
        md_stall_cnt <= md_stall_cnt + STAT_ONE;
      end
    end
  end
`else
  assign stall_cnt    = '0;
  assign md_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a table of single-cycle hazard
// vectors plus hand-written MULT/DIV busy, restart and reset sequences.
// Statistics expectations follow HAZARD_STATS_EN (zero when undefined).
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1_d, a2_d, waddr_e, waddr_m;
  logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic        md_use_d, md_start_e, md_is_div_e;
  logic        en_pc, en_ifid, clr_idex, md_busy;
  logic [31:0] stall_cnt, md_stall_cnt;

  int tests  = 0;
  int failed = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_md    = 32'd0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .a1_d         (a1_d),
    .a2_d         (a2_d),
    .tuse_rs_d    (tuse_rs_d),
    .tuse_rt_d    (tuse_rt_d),
    .waddr_e      (waddr_e),
    .tnew_e       (tnew_e),
    .waddr_m      (waddr_m),
    .tnew_m       (tnew_m),
    .md_use_d     (md_use_d),
    .md_start_e   (md_start_e),
    .md_is_div_e  (md_is_div_e),
    .en_pc        (en_pc),
    .en_ifid      (en_ifid),
    .clr_idex     (clr_idex),
    .md_busy      (md_busy),
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt)
  );

  typedef struct {
    logic [4:0] a1, a2;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] we;
    logic [1:0] te;
    logic [4:0] wm;
    logic [1:0] tm;
    logic       md_use;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    a1_d = 5'd0; a2_d = 5'd0; tuse_rs_d = 2'd3; tuse_rt_d = 2'd3;
    waddr_e = 5'd0; tnew_e = 2'd0; waddr_m = 5'd0; tnew_m = 2'd0;
    md_use_d = 1'b0; md_start_e = 1'b0; md_is_div_e = 1'b0;
  endtask

  // Sample one cycle at negedge, update the statistics model, advance past posedge.
  task automatic tick(input string name, input logic exp_stall, input logic exp_busy);
    logic exp_md;
    logic [31:0] exp_sc, exp_mc;
    @(negedge clk);
    exp_md = md_use_d & (exp_busy | md_start_e) & ~reset;
    check({name, ".ctl"}, {29'd0, en_pc, en_ifid, clr_idex},
          exp_stall ? 32'd1 : 32'd6);
    check({name, ".busy"}, {31'd0, md_busy}, {31'd0, exp_busy});
`ifdef HAZARD_STATS_EN
    exp_sc = m_stall;
    exp_mc = m_md;
`else
    exp_sc = 32'd0;
    exp_mc = 32'd0;
`endif
    check({name, ".scnt"}, stall_cnt, exp_sc);
    check({name, ".mcnt"}, md_stall_cnt, exp_mc);
    if (reset) begin
      m_stall = 32'd0;
      m_md    = 32'd0;
    end else begin
      if (exp_stall) m_stall = m_stall + 32'd1;
      if (exp_md)    m_md    = m_md + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            a1     a2     trs   trt   we     te    wm     tm    md    stall
    vecs[0] = '{5'd1,  5'd3,  2'd1, 2'd3, 5'd1,  2'd2, 5'd0,  2'd0, 1'b0, 1'b1}; // lw $1 / addu
    vecs[1] = '{5'd1,  5'd3,  2'd1, 2'd3, 5'd0,  2'd0, 5'd1,  2'd1, 1'b0, 1'b0}; // lw now in M
    vecs[2] = '{5'd0,  5'd3,  2'd1, 2'd3, 5'd0,  2'd2, 5'd0,  2'd0, 1'b0, 1'b0}; // $0 never hazards
    vecs[3] = '{5'd0,  5'd5,  2'd3, 2'd0, 5'd0,  2'd0, 5'd5,  2'd1, 1'b0, 1'b1}; // rt vs M
    vecs[4] = '{5'd4,  5'd0,  2'd3, 2'd3, 5'd4,  2'd2, 5'd0,  2'd0, 1'b0, 1'b0}; // rs unused
    vecs[5] = '{5'd7,  5'd0,  2'd0, 2'd3, 5'd7,  2'd0, 5'd0,  2'd0, 1'b0, 1'b0}; // forwardable
    vecs[6] = '{5'd7,  5'd0,  2'd0, 2'd3, 5'd8,  2'd2, 5'd0,  2'd0, 1'b0, 1'b0}; // other reg
    vecs[7] = '{5'd0,  5'd31, 2'd3, 2'd1, 5'd31, 2'd2, 5'd0,  2'd0, 1'b0, 1'b1}; // rt vs E, $31
    vecs[8] = '{5'd0,  5'd0,  2'd3, 2'd3, 5'd0,  2'd0, 5'd0,  2'd0, 1'b1, 1'b0}; // md idle
    vecs[9] = '{5'd3,  5'd9,  2'd1, 2'd2, 5'd0,  2'd0, 5'd3,  2'd2, 1'b0, 1'b1}; // rs vs M

    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    md_use_d = 1'b1; md_start_e = 1'b1;
    tick("reset_hold", 1'b0, 1'b0);
    idle_inputs();
    reset = 1'b0;
    tick("after_reset", 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      a1_d = vecs[i].a1; a2_d = vecs[i].a2;
      tuse_rs_d = vecs[i].tuse_rs; tuse_rt_d = vecs[i].tuse_rt;
      waddr_e = vecs[i].we; tnew_e = vecs[i].te;
      waddr_m = vecs[i].wm; tnew_m = vecs[i].tm;
      md_use_d = vecs[i].md_use;
      tick($sformatf("vec%0d", i), vecs[i].exp_stall, 1'b0);
    end
    idle_inputs();

    // MULT then mflo in D: start cycle plus 5 busy cycles stall.
    md_use_d = 1'b1; md_start_e = 1'b1; md_is_div_e = 1'b0;
    tick("mult_k0", 1'b1, 1'b0);
    md_start_e = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick($sformatf("mult_k%0d", k), k <= 5, k <= 5);
    end
    idle_inputs();

    // DIV: busy for exactly 10 cycles.
    md_start_e = 1'b1; md_is_div_e = 1'b1;
    tick("div_k0", 1'b0, 1'b0);
    md_start_e = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick($sformatf("div_k%0d", k), 1'b0, k <= 10);
    end

    // DIV again, reset on busy cycle 4 aborts the window.
    md_start_e = 1'b1; md_is_div_e = 1'b1;
    tick("divr_k0", 1'b0, 1'b0);
    md_start_e = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick($sformatf("divr_k%0d", k), 1'b0, 1'b1);
    end
    reset = 1'b1; md_use_d = 1'b1;
    tick("divr_rst", 1'b0, 1'b1);
    reset = 1'b0;
    tick("divr_k5", 1'b0, 1'b0);
    tick("divr_k6", 1'b0, 1'b0);
    idle_inputs();

    // Restart: DIV, then MULT three cycles later; busy ends 5 cycles after it.
    md_start_e = 1'b1; md_is_div_e = 1'b1;
    tick("rs_k0", 1'b0, 1'b0);
    md_start_e = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      md_start_e  = (k == 3);
      md_is_div_e = 1'b0;
      tick($sformatf("rs_k%0d", k), 1'b0, k <= 8);
    end
    idle_inputs();

    // Data and MD stall together: counted once in each counter.
    a1_d = 5'd2; tuse_rs_d = 2'd0; waddr_e = 5'd2; tnew_e = 2'd1;
    md_use_d = 1'b1; md_start_e = 1'b1; md_is_div_e = 1'b0;
    tick("both_k0", 1'b1, 1'b0);
    idle_inputs();
    for (int k = 1; k <= 5; k++) begin
      tick($sformatf("both_k%0d", k), 1'b0, 1'b1);
    end
    tick("final", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
